// File: rtl/frame_pkg.sv
// Shared widths and tag layout for the frame packetizer.
// Tag bits sit directly above the sample data in each FIFO word.
package frame_pkg;

    localparam int FRAME_CNT_W = 16;
    localparam int TAG_BITS    = 2;
    localparam int SOF_TAG     = 1;
    localparam int EOF_TAG     = 0;

    // Field order matches SOF_TAG/EOF_TAG: sof is the upper tag bit.
    typedef struct packed {
        logic sof;
        logic eof;
    } tag_t;

endpackage

// File: rtl/frame_packetizer_if.sv
// Sample stream in (strobe only) and ready/valid tagged stream out.
// master: the packetizer side; slave: the source/consumer side.
interface frame_packetizer_if #(
    parameter int BITS = 8
);
    logic            in_valid;
    logic [BITS-1:0] data_in;
    logic            m_valid;
    logic            m_ready;
    logic [BITS-1:0] m_data;
    logic            m_sof;
    logic            m_eof;

    modport master (
        input  in_valid, data_in, m_ready,
        output m_valid, m_data, m_sof, m_eof
    );

    modport slave (
        output in_valid, data_in, m_ready,
        input  m_valid, m_data, m_sof, m_eof
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; dout shows the head, zero when empty.
// Latency: 1 cycle push-to-visible; full accepts a push only alongside a pop.
module sync_fifo_fwft #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign dout = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/frame_packetizer.sv
// Slices a stall-free sample stream into N-sample frames with sof/eof tags (FRAME_GAP_EN adds idle-frame abandon).
// Latency: 1 cycle from in_valid to m_valid on an empty FIFO.
// Backpressure: input cannot stall; a sample arriving on a full FIFO with no pop is dropped and flagged.
module frame_packetizer
    import frame_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int N          = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    frame_packetizer_if.master     bus,
    input  logic                   clr_status,
    output logic                   overflow,
    output logic                   gap_err,
    output logic [FRAME_CNT_W-1:0] frame_count
);
    localparam int             IW       = $clog2(N);
    localparam int             FW       = BITS + TAG_BITS;
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    logic [IW-1:0]          r_idx;
    logic                   r_overflow;
    logic [FRAME_CNT_W-1:0] r_frame_count;

    tag_t                   w_tag;
    logic [FW-1:0]          w_fifo_din;
    logic [FW-1:0]          w_fifo_dout;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_ovf_set;
    logic                   w_eof_pop;
    logic                   w_gap_set;

    always_comb begin
        w_tag     = '0;
        w_tag.sof = (r_idx == '0);
        w_tag.eof = (r_idx == LAST_IDX);
    end

    assign w_fifo_din = {w_tag, bus.data_in};

    sync_fifo_fwft #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.in_valid),
        .din   (w_fifo_din),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .empty (w_empty)
    );

    assign bus.m_valid = !w_empty;
    assign bus.m_data  = w_fifo_dout[BITS-1:0];
    assign bus.m_sof   = w_fifo_dout[BITS + SOF_TAG];
    assign bus.m_eof   = w_fifo_dout[BITS + EOF_TAG];

    assign w_pop     = !w_empty && bus.m_ready;
    assign w_ovf_set = bus.in_valid && w_full && !w_pop;
    assign w_eof_pop = w_pop && bus.m_eof;

    // idx advances even for dropped samples so frame alignment survives overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (bus.in_valid) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end else if (w_gap_set) begin
            r_idx <= '0;
        end
    end

`ifdef FRAME_GAP_EN
    localparam int             TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_gap_tmr;
    logic          r_gap_err;

    assign w_gap_set = !bus.in_valid && (r_idx != '0) && (r_gap_tmr == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_tmr <= '0;
        end else if (bus.in_valid || (r_idx == '0) || w_gap_set) begin
            r_gap_tmr <= '0;
        end else begin
            r_gap_tmr <= r_gap_tmr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_err <= 1'b0;
        end else if (clr_status) begin
            r_gap_err <= w_gap_set;
        end else if (w_gap_set) begin
            r_gap_err <= 1'b1;
        end
    end

    assign gap_err = r_gap_err;
`else
    // No timer: a partial frame waits indefinitely; the flag is constant 0 for any legal TIMEOUT.
    assign w_gap_set = 1'b0;
    assign gap_err   = (TIMEOUT < 0);
`endif

    // A set event in the same cycle as clr_status survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow    <= 1'b0;
            r_frame_count <= '0;
        end else if (clr_status) begin
            r_overflow    <= w_ovf_set;
            r_frame_count <= FRAME_CNT_W'(w_eof_pop);
        end else begin
            if (w_ovf_set) r_overflow    <= 1'b1;
            if (w_eof_pop) r_frame_count <= r_frame_count + 1'b1;
        end
    end

    assign overflow    = r_overflow;
    assign frame_count = r_frame_count;

endmodule
